// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned PC_STEP = 4;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  typedef enum logic {
    RUN,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries; flush wins over push, head is registered.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           push_entry,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] remaining;
  fetch_entry_t     head_d;

  // Head register holds its last value once the FIFO drains.
  always_comb begin
    remaining = count - CNT_W'(pop);
    head_d    = head;
    if (remaining != '0) begin
      head_d = mem[rd_ptr + PTR_W'(pop)];
    end else if (push) begin
      head_d = push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      head <= head_d;
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: credit-limited word fetches over req/ack into a prefetch FIFO,
// with redirect flush and a drain state for a request already in flight.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 mem_req_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  input  logic                 mem_ack_i,
  input  logic [INSTR_W-1:0]   mem_data_i,
  input  logic                 redirect_i,
  input  logic [ADDR_W-1:0]    redirect_pc_i,
  output logic                 instr_valid_o,
  output logic [INSTR_W-1:0]   instr_o,
  output logic [ADDR_W-1:0]    instr_pc_o,
  input  logic                 instr_ready_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  count, count_d;
  logic              fire, hold, push, pop;
  fetch_entry_t      push_entry, head;

  assign fire = req_q && mem_ack_i;
  assign hold = req_q && !mem_ack_i;
  assign pop  = instr_valid_o && instr_ready_i;
  assign push = fire && (state_q == RUN) && !redirect_i;

  assign push_entry.instr = mem_data_i;
  assign push_entry.pc    = addr_q;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_i),
    .push_entry(push_entry),
    .head      (head),
    .count     (count)
  );

  // Credit is judged on next-cycle occupancy; an unacked request keeps its address.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~ADDR_W'(3);
      state_d    = hold ? DRAIN : RUN;
    end else if (fire) begin
      state_d = RUN;
      if (state_q == RUN) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
    end
    count_d = redirect_i ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    req_d   = hold || (count_d < CNT_W'(DEPTH));
    addr_d  = hold ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign mem_req_o     = req_q;
  assign mem_addr_o    = addr_q;
  assign instr_valid_o = (count != '0);
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;

  instr_fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: expected FIFO contents as a queue of {instr, pc}.
  logic [63:0] q[$];
  logic [31:0] reqs[$];
  logic [31:0] popped[$];
  logic        m_out;
  logic        m_drain;
  logic [31:0] m_addr;
  logic [31:0] fpc;
  logic [63:0] last;
  int          fires;

  // Memory behaviour: 0 = fixed latency, 1 = random ack, 2 = ack always high.
  int ack_mode = 2;
  int lat      = 0;
  int wcnt     = 0;

  int first_valid;
  int hits;
  bit found;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_out   = 1'b0;
    m_drain = 1'b0;
    m_addr  = RESET_PC;
    fpc     = RESET_PC;
    last    = '0;
    wcnt    = 0;
  endtask

  // Called at a negedge: check outputs, drive inputs, advance model, move to next negedge.
  task automatic step(input logic rdy, input logic rd, input logic [31:0] tgt);
    logic        fire, hold;
    logic [63:0] e;
    check("mem_req", 32'(mem_req_o), 32'(m_out));
    if (m_out) check("mem_addr", mem_addr_o, m_addr);
    check("instr_valid", 32'(instr_valid_o), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("instr", instr_o, q[0][63:32]);
      check("instr_pc", instr_pc_o, q[0][31:0]);
    end else begin
      check("instr_hold", instr_o, last[63:32]);
      check("instr_pc_hold", instr_pc_o, last[31:0]);
    end

    instr_ready_i = rdy;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    case (ack_mode)
      0:       mem_ack_i = mem_req_o && (wcnt >= lat);
      1:       mem_ack_i = 1'($urandom_range(0, 1));
      default: mem_ack_i = 1'b1;
    endcase
    mem_data_i = word(mem_addr_o);

    if (mem_req_o && mem_ack_i) wcnt = 0;
    else if (mem_req_o) wcnt++;

    fire = m_out && mem_ack_i;
    hold = m_out && !mem_ack_i;
    if (fire) fires++;
    if (q.size() != 0 && rdy) begin
      e = q.pop_front();
      popped.push_back(e[31:0]);
    end
    if (rd) begin
      q.delete();
      fpc     = tgt & 32'hFFFF_FFFC;
      m_drain = hold;
    end else if (fire) begin
      if (!m_drain) begin
        q.push_back({word(m_addr), m_addr});
        fpc = fpc + 32'd4;
      end
      m_drain = 1'b0;
    end
    if (!hold) begin
      m_out  = (q.size() < DEPTH);
      m_addr = fpc;
      if (m_out) reqs.push_back(fpc);
    end
    if (q.size() != 0) last = q[0];

    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i         = 1'b0;
    mem_ack_i     = 1'b0;
    redirect_i    = 1'b0;
    instr_ready_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_addr", mem_addr_o, RESET_PC);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc", instr_pc_o, 32'd0);
    rst_i = 1'b1;
    reqs.delete();
    popped.delete();
    fires = 0;
  endtask

  initial begin
    // Zero-wait memory, consumer always ready.
    do_reset();
    ack_mode    = 2;
    first_valid = -1;
    for (int i = 0; i < 8; i++) begin
      if (instr_valid_o && first_valid < 0) first_valid = i;
      step(1'b1, 1'b0, '0);
    end
    check("first_valid_cycle", 32'(first_valid), 32'd2);
    if (popped.size() >= 3) begin
      check("seq_pc0", popped[0], 32'h0);
      check("seq_pc1", popped[1], 32'h4);
      check("seq_pc2", popped[2], 32'h8);
    end else check("seq_len", 32'(popped.size()), 32'd3);

    // Consumer stalled: credit must stop at DEPTH acks.
    do_reset();
    repeat (10) step(1'b0, 1'b0, '0);
    check("stall_acks", 32'(fires), 32'(DEPTH));
    check("stall_req_low", 32'(mem_req_o), 32'd0);
    check("stall_full", 32'(instr_valid_o), 32'd1);
    reqs.delete();
    step(1'b1, 1'b0, '0);
    repeat (4) step(1'b0, 1'b0, '0);
    check("one_new_req", 32'(reqs.size()), 32'd1);
    if (reqs.size() != 0) check("new_req_addr", reqs[0], 32'h10);

    // Redirect while a slow request to 8 is pending.
    do_reset();
    ack_mode = 0;
    lat      = 2;
    found    = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_out && m_addr == 32'h8 && wcnt == 0) found = 1;
      else step(1'b1, 1'b0, '0);
    end
    check("find_pend8", 32'(found), 32'd1);
    step(1'b1, 1'b1, 32'h0000_0103);
    check("drain_addr_held", mem_addr_o, 32'h8);
    check("drain_req_held", 32'(mem_req_o), 32'd1);
    reqs.delete();
    popped.delete();
    repeat (20) step(1'b1, 1'b0, '0);
    if (reqs.size() != 0) check("post_drain_req", reqs[0], 32'h100);
    else check("post_drain_req_cnt", 32'(reqs.size()), 32'd1);
    if (popped.size() != 0) check("post_drain_pc", popped[0], 32'h100);
    else check("post_drain_pop_cnt", 32'(popped.size()), 32'd1);
    hits = 0;
    foreach (popped[i]) if (popped[i] == 32'h8) hits++;
    check("pc8_dropped", 32'(hits), 32'd0);

    // Redirect in the same cycle as the ack of address 12.
    do_reset();
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_out && m_addr == 32'hC && wcnt == lat) found = 1;
      else step(1'b1, 1'b0, '0);
    end
    check("find_ack12", 32'(found), 32'd1);
    popped.delete();
    step(1'b1, 1'b1, 32'h0000_0040);
    check("redir_ack_req", 32'(mem_req_o), 32'd1);
    check("redir_ack_addr", mem_addr_o, 32'h40);
    repeat (15) step(1'b1, 1'b0, '0);
    hits = 0;
    foreach (popped[i]) if (popped[i] == 32'hC) hits++;
    check("pc12_dropped", 32'(hits), 32'd0);

    // Address wrap at the top of the space.
    do_reset();
    ack_mode = 2;
    step(1'b1, 1'b0, '0);
    reqs.delete();
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (4) step(1'b1, 1'b0, '0);
    if (reqs.size() >= 2) begin
      check("wrap_req0", reqs[0], 32'hFFFF_FFFC);
      check("wrap_req1", reqs[1], 32'h0);
    end else check("wrap_req_cnt", 32'(reqs.size()), 32'd2);

    // Asynchronous reset while draining, then a stale ack.
    do_reset();
    ack_mode = 0;
    found    = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out && wcnt == 0 && m_addr != RESET_PC) found = 1;
      else step(1'b1, 1'b0, '0);
    end
    check("find_pend", 32'(found), 32'd1);
    step(1'b1, 1'b1, 32'h0000_0200);
    check("drain_pending", 32'(mem_req_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    check("async_req_drop", 32'(mem_req_o), 32'd0);
    check("async_valid_drop", 32'(instr_valid_o), 32'd0);
    model_reset();
    ack_mode   = 2;
    mem_ack_i  = 1'b1;
    redirect_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    reqs.delete();
    popped.delete();
    repeat (6) step(1'b1, 1'b0, '0);
    if (reqs.size() != 0) check("post_rst_req", reqs[0], RESET_PC);
    else check("post_rst_req_cnt", 32'(reqs.size()), 32'd1);
    if (popped.size() != 0) check("post_rst_pc", popped[0], RESET_PC);
    else check("post_rst_pop_cnt", 32'(popped.size()), 32'd1);

    // Random traffic: ack, ready and redirects all random.
    do_reset();
    ack_mode = 1;
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
